// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single register-file write port between load writebacks, which
// have fixed priority, and ALU writebacks, which wait in a small FIFO. A
// starvation counter forces an ALU slot after STARVE_LIMIT blocked cycles.
// The stall output tells decode when a source register still has a write
// that the register file does not show yet.
module regfile_write_arbiter #(
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 5,
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4,
    localparam int PTR_W       = $clog2(BUF_DEPTH),
    localparam int CNT_W       = $clog2(BUF_DEPTH) + 1,
    localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_alu_valid,
    output logic              o_alu_ready,
    input  logic [ADDR_W-1:0] i_alu_rd,
    input  logic [DATA_W-1:0] i_alu_data,
    input  logic              i_mem_valid,
    output logic              o_mem_ready,
    input  logic [ADDR_W-1:0] i_mem_rd,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [ADDR_W-1:0] i_RS1,
    input  logic [ADDR_W-1:0] i_RS2,
    output logic              o_stall,
    output logic              o_RegWrite,
    output logic [ADDR_W-1:0] o_RD,
    output logic [DATA_W-1:0] o_WriteData,
    output logic [CNT_W-1:0]  o_alu_count
);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    wb_req_t            r_fifo [BUF_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic [SW-1:0]      r_starve;
    logic               r_RegWrite;
    logic [ADDR_W-1:0]  r_RD;
    logic [DATA_W-1:0]  r_WriteData;

    logic               w_nonempty;
    logic               w_force_alu;
    logic               w_push;
    logic               w_mem_issue;
    logic               w_alu_pop;
    logic [BUF_DEPTH-1:0] w_slot_vld;
    logic               w_hit1;
    logic               w_hit2;
    wb_req_t            w_head;

    // Handshakes and arbitration are driven from registered occupancy only,
    // so a pop in this cycle cannot open a slot for a push in this cycle.
    assign w_nonempty  = (r_count != '0);
    assign w_force_alu = (r_starve == SW'(STARVE_LIMIT)) && w_nonempty;
    assign o_alu_ready = !i_reset && (r_count < CNT_W'(BUF_DEPTH));
    assign o_mem_ready = !i_reset && !w_force_alu;
    assign w_push      = i_alu_valid && o_alu_ready;
    assign w_mem_issue = i_mem_valid && o_mem_ready;
    assign w_alu_pop   = !i_reset && !w_mem_issue && w_nonempty;
    assign w_head      = r_fifo[r_rptr];

    // A slot is live when its distance from the read pointer is below occupancy.
    for (genvar g = 0; g < BUF_DEPTH; g++) begin : g_slot
        logic [PTR_W-1:0] w_off;
        assign w_off         = PTR_W'(g) - r_rptr;
        assign w_slot_vld[g] = ({1'b0, w_off} < r_count);
    end

    // Source match against buffered entries and the write landing this cycle.
    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (w_slot_vld[i] && (r_fifo[i].rd == i_RS1)) w_hit1 = 1'b1;
            if (w_slot_vld[i] && (r_fifo[i].rd == i_RS2)) w_hit2 = 1'b1;
        end
        if (r_RegWrite && (r_RD == i_RS1)) w_hit1 = 1'b1;
        if (r_RegWrite && (r_RD == i_RS2)) w_hit2 = 1'b1;
    end

    assign o_stall = !i_reset && (((i_RS1 != '0) && w_hit1) ||
                                  ((i_RS2 != '0) && w_hit2));

    // FIFO storage write; contents need no reset since occupancy gates use.
    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo[r_wptr] <= '{rd: i_alu_rd, data: i_alu_data};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)    r_wptr <= r_wptr + PTR_W'(1);
            if (w_alu_pop) r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_alu_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Starvation counter: counts load wins over a waiting ALU entry.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_alu_pop || !w_nonempty) begin
            r_starve <= '0;
        end else if (w_mem_issue && (r_starve != SW'(STARVE_LIMIT))) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    // Registered write port; rd==0 is consumed but never written.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_RegWrite  <= 1'b0;
            r_RD        <= '0;
            r_WriteData <= '0;
        end else if (w_mem_issue) begin
            r_RegWrite  <= (i_mem_rd != '0);
            r_RD        <= i_mem_rd;
            r_WriteData <= i_mem_data;
        end else if (w_alu_pop) begin
            r_RegWrite  <= (w_head.rd != '0);
            r_RD        <= w_head.rd;
            r_WriteData <= w_head.data;
        end else begin
            r_RegWrite  <= 1'b0;
        end
    end

    assign o_RegWrite  = r_RegWrite;
    assign o_RD        = r_RD;
    assign o_WriteData = r_WriteData;
    assign o_alu_count = r_count;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x64 register file between two writeback sources: ALU results and memory-load results.
- Load writebacks get fixed priority. ALU writebacks are buffered in a small FIFO and drained when the port is free.
- A starvation counter guarantees ALU forward progress.
- Provides a read-after-write stall signal for decode, since writes reaching the register file are delayed by arbitration.

Parameters:
DATA_W, 64, register data width
ADDR_W, 5, register index width
BUF_DEPTH, 2, ALU holding FIFO depth (power of 2, >=2)
STARVE_LIMIT, 4, consecutive cycles a non-empty ALU FIFO may be blocked before a forced ALU slot

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
alu_valid  input  1  ALU writeback request
alu_ready  output  1  FIFO can accept ALU request
alu_rd  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
mem_valid  input  1  load writeback request
mem_ready  output  1  load request accepted this cycle
mem_rd  input  ADDR_W  load destination register
mem_data  input  DATA_W  load data
RS1  input  ADDR_W  decode source register 1
RS2  input  ADDR_W  decode source register 2
stall  output  1  a decode source has a write not yet visible in the register file
RegWrite  output  1  register file write enable (registered)
RD  output  ADDR_W  register file write index (registered)
WriteData  output  DATA_W  register file write data (registered)
alu_count  output  clog2(BUF_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (synchronous, active-high):
  - At the edge with reset=1: FIFO empty, alu_count=0, starve counter=0, RegWrite=0, RD=0, WriteData=0.
  - While reset=1: alu_ready=0, mem_ready=0, stall=0. Requests presented during reset are discarded.
  - A reset arriving mid-operation discards buffered entries and any in-flight issue.
- ALU handshake:
  - alu_ready = !reset && (alu_count < BUF_DEPTH), computed from registered occupancy only. A pop in the same cycle never makes a full FIFO ready.
  - Push on alu_valid && alu_ready.
- Mem handshake:
  - mem_ready = !reset && !force_alu.
  - force_alu = (starve counter == STARVE_LIMIT) && FIFO non-empty.
  - No buffering: an unaccepted load must be held by the source.
- Arbitration, one issue per cycle:
  - If mem_valid && mem_ready: issue the load.
  - Else if the FIFO is non-empty: pop the head and issue it.
  - Else: no issue.
  - An ALU entry pushed in cycle N is poppable at the earliest in cycle N+1 (no FIFO bypass).
- Issue output:
  - Issued request appears on RegWrite/RD/WriteData at the next edge, held for exactly one cycle.
  - RegWrite=1 only if the issued rd != 0. Writes to x0 are consumed (popped or accepted) but produce RegWrite=0.
- Latency:
  - Load: 1 cycle from acceptance to RegWrite.
  - ALU: minimum 2 cycles from push to RegWrite.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the load wins.
  - Clears on any ALU pop, and when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - A forced cycle pops the ALU head and clears the counter.
- Ordering:
  - ALU entries issue in FIFO order.
  - Between sources, register file update order equals issue order. The later-issued write to the same rd wins.
- Simultaneous events:
  - Push and pop in the same cycle leaves alu_count unchanged.
  - Push into an empty FIFO while a load issues: the entry waits.
- Stall (combinational):
  - For each nonzero source register, stall=1 if it equals the rd of any valid FIFO entry, or equals RD while RegWrite=1.
  - RS=0 never stalls.
  - The registered output is included because the register file write completes on that cycle's edge.
- FIFO storage: pointer wrap modulo BUF_DEPTH. Occupancy counter is separate from the pointers so full and empty are unambiguous.

Test Plan:
- Reset then idle: assert reset 2 cycles with alu_valid=1 → alu_ready=0, mem_ready=0, RegWrite=0, alu_count=0. First cycle after reset: alu_ready=1.
- Single ALU write: alu_rd=5, alu_data=0xDEAD at cycle 0 → alu_count=1 at cycle 1; RegWrite=1, RD=5, WriteData=0xDEAD at cycle 2 only.
- Collision: load (rd=7, 0x11) and FIFO head (rd=3, 0x22) both pending → RD=7 issued first, RD=3 the next cycle. Check stall=1 for RS1=3 until the RD=3 write cycle has passed.
- Starvation: mem_valid held high continuously, FIFO holding one entry → after 4 load issues, mem_ready=0 for one cycle and the ALU entry is issued; then the counter is 0 and mem_ready=1.
- Full FIFO: push 2 entries with the port blocked by loads → alu_ready=0, and a third alu_valid is not accepted. A pop plus a push attempt in the same cycle leaves alu_count=1, not 2.
- x0 and mid-reset: ALU write to rd=0 is popped with RegWrite=0 and stall=0 for RS1=0. Asserting reset with 2 buffered entries produces no RegWrite afterward, and alu_count=0.
